// File: rtl/cdr_tracking_lock.sv
// Oversampling clock/data recovery: d_in synchroniser, edge-reset phase alignment,
// saturating delta-sigma frequency trim and a lock/loss detector with soft enable.
module cdr_tracking_lock #(
  parameter int unsigned OSR         = 8,
  parameter int unsigned DS_WIDTH    = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned INC_LIMIT   = 63,
  parameter int unsigned LOCK_TOL    = 1,
  parameter int unsigned LOCK_EDGES  = 16,
  parameter int unsigned UNLOCK_ERRS = 4,
  parameter int unsigned MAX_RUN     = 32
) (
  input  logic                       clk_x8,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       freeze,
  input  logic                       d_in,
  output logic                       d_out,
  output logic                       d_out_valid,
  output logic                       clk_out,
  output logic                       locked,
  output logic signed [DS_WIDTH-1:0] ds_inc
);

  localparam int unsigned CNT_W  = $clog2(OSR + 1);
  localparam int unsigned GOOD_W = $clog2(LOCK_EDGES + 1);
  localparam int unsigned BAD_W  = $clog2(UNLOCK_ERRS + 1);
  localparam int unsigned RUN_W  = $clog2(MAX_RUN + 1);

  localparam logic signed [CNT_W:0]    TOL    = (CNT_W+1)'(LOCK_TOL);
  localparam logic signed [DS_WIDTH:0] INC_HI = (DS_WIDTH+1)'(INC_LIMIT);
  localparam logic signed [DS_WIDTH:0] INC_LO = -INC_HI;

  typedef enum logic {ACQ = 1'b0, LOCKED = 1'b1} lock_state_t;

  logic [SYNC_STAGES-1:0]     sync_q;
  logic                       hist_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [DS_WIDTH-1:0]        ds_acc_q;
  logic [CNT_W-1:0]           top_c;
  logic [CNT_W-1:0]           samp_c;
  logic                       edge_c;
  logic                       wrap_c;
  logic                       samp_hit_c;
  logic                       good_edge_c;
  logic signed [CNT_W:0]      perr_c;
  logic signed [DS_WIDTH:0]   inc_sum_c;
  logic signed [DS_WIDTH-1:0] inc_next_c;

  lock_state_t       state_q, state_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [BAD_W-1:0]  bad_q, bad_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic              locked_d;

  // Synchroniser and edge history run through soft reset
  always_ff @(posedge clk_x8 or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Period selection, phase error and clamped trim update
  always_comb begin
    edge_c = sync_q[SYNC_STAGES-1] ^ hist_q;
    top_c  = CNT_W'(OSR - 1);
    if (ds_acc_q[DS_WIDTH-1]) begin
      top_c = ds_inc[DS_WIDTH-1] ? CNT_W'(OSR - 2) : CNT_W'(OSR);
    end
    samp_c     = top_c >> 1;
    wrap_c     = (cnt_q == top_c);
    samp_hit_c = (cnt_q == samp_c);
    if (cnt_q < samp_c) begin
      perr_c = $signed({1'b0, cnt_q});
    end else begin
      perr_c = $signed({1'b0, cnt_q}) - $signed({1'b0, top_c});
    end
    good_edge_c = (perr_c <= TOL) && (perr_c >= -TOL);
    inc_sum_c   = $signed({ds_inc[DS_WIDTH-1], ds_inc})
                + $signed({{(DS_WIDTH-CNT_W){perr_c[CNT_W]}}, perr_c});
    inc_next_c  = DS_WIDTH'(inc_sum_c);
    if (inc_sum_c > INC_HI) begin
      inc_next_c = DS_WIDTH'(INC_HI);
    end else if (inc_sum_c < INC_LO) begin
      inc_next_c = DS_WIDTH'(INC_LO);
    end
  end

  // Bit counter, sampling, recovered clock and delta-sigma accumulator
  always_ff @(posedge clk_x8 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      clk_out     <= 1'b0;
      d_out       <= 1'b0;
      d_out_valid <= 1'b0;
      ds_acc_q    <= '0;
      ds_inc      <= '0;
    end else if (!en) begin
      cnt_q       <= '0;
      clk_out     <= 1'b0;
      d_out       <= 1'b0;
      d_out_valid <= 1'b0;
      ds_acc_q    <= '0;
      ds_inc      <= '0;
    end else begin
      d_out_valid <= 1'b0;
      if (wrap_c) begin
        cnt_q    <= '0;
        clk_out  <= 1'b0;
        ds_acc_q <= {1'b0, ds_acc_q[DS_WIDTH-2:0]} + $unsigned(ds_inc);
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (samp_hit_c) begin
          clk_out     <= 1'b1;
          d_out       <= hist_q;
          d_out_valid <= 1'b1;
        end
      end
      // A data edge realigns the bit phase; the sample above still lands
      if (edge_c) begin
        cnt_q   <= '0;
        clk_out <= 1'b0;
        if (!freeze) begin
          ds_inc <= inc_next_c;
        end
      end
    end
  end

  // Lock detector state register
  always_ff @(posedge clk_x8 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACQ;
      good_q  <= '0;
      bad_q   <= '0;
      run_q   <= '0;
      locked  <= 1'b0;
    end else if (!en) begin
      state_q <= ACQ;
      good_q  <= '0;
      bad_q   <= '0;
      run_q   <= '0;
      locked  <= 1'b0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      run_q   <= run_d;
      locked  <= locked_d;
    end
  end

  // Lock detector next state; an edge coinciding with a wrap counts as an edge
  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    bad_d    = bad_q;
    run_d    = run_q;
    locked_d = locked;
    unique case (state_q)
      ACQ: begin
        if (edge_c) begin
          if (!good_edge_c) begin
            good_d = '0;
          end else if (good_q != GOOD_W'(LOCK_EDGES)) begin
            good_d = good_q + GOOD_W'(1);
          end
          if (good_d == GOOD_W'(LOCK_EDGES)) begin
            state_d  = LOCKED;
            locked_d = 1'b1;
            good_d   = '0;
            bad_d    = '0;
            run_d    = '0;
          end
        end
      end
      LOCKED: begin
        if (edge_c) begin
          run_d = '0;
          if (good_edge_c) begin
            bad_d = '0;
          end else if (bad_q != BAD_W'(UNLOCK_ERRS)) begin
            bad_d = bad_q + BAD_W'(1);
          end
        end else if (wrap_c && (run_q != RUN_W'(MAX_RUN))) begin
          run_d = run_q + RUN_W'(1);
        end
        if ((bad_d == BAD_W'(UNLOCK_ERRS)) || (run_d == RUN_W'(MAX_RUN))) begin
          state_d  = ACQ;
          locked_d = 1'b0;
          good_d   = '0;
          bad_d    = '0;
          run_d    = '0;
        end
      end
      default: state_d = ACQ;
    endcase
  end

endmodule
